// File: rtl/seq_mul_pkg.sv
// Shared types and elaboration helpers for the radix-2^K sequential multiplier.
// Operand widths up to 32 bits are supported by the magnitude helper.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nstep(input int width, input int k);
    return width / k;
  endfunction

  function automatic bit params_ok(input int width, input int k, input int early_term);
    return (width >= 2) && (width <= 32) &&
           ((k == 1) || (k == 2) || (k == 4)) && ((width % k) == 0) &&
           ((early_term == 0) || (early_term == 1));
  endfunction

  // Magnitude of a width-bit operand held in the low bits of v; upper bits come back zero.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input int width,
                                          input logic is_sgn);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (is_sgn && v[width-1]) return (~v + 32'd1) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Datapath of the radix-2^K multiplier: operand magnitudes, accumulator, digit counter
// and the final sign correction of acc + current partial product.
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int K          = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 finish_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 is_signed_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int NSTEP = nstep(WIDTH, K);
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  logic [PW-1:0]    as_q, as_d, acc_q, acc_d;
  logic [WIDTH-1:0] bs_q, bs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    pp, sum;

  assign pp       = as_q * PW'(bs_q[K-1:0]);
  assign sum      = acc_q + pp;
  assign result_o = neg_q ? (PW'(0) - sum) : sum;
  assign last_o   = (cnt_q == CW'(NSTEP - 1)) ||
                    ((EARLY_TERM != 0) && ((bs_q >> K) == '0));

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    as_d  = as_q;
    bs_d  = bs_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    if (load_i) begin
      neg_d = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      as_d  = PW'(abs_val(32'(a_i), WIDTH, is_signed_i));
      bs_d  = WIDTH'(abs_val(32'(b_i), WIDTH, is_signed_i));
      acc_d = '0;
      cnt_d = '0;
    end else if (step_i && !finish_i) begin
      // The final digit is folded into the result combinationally, so the registers freeze there.
      acc_d = sum;
      as_d  = as_q << K;
      bs_d  = bs_q >> K;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments and are all cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_q  <= '0;
      bs_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      as_q  <= as_d;
      bs_q  <= bs_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  end

endmodule

// File: rtl/seq_mul_radix.sv
// Sequential radix-2^K shift-add multiplier with valid/ready handshakes on both sides.
// Holds the IDLE/CALC/DONE controller and the registered ready, o_valid and P outputs.
module seq_mul_radix
  import seq_mul_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int K          = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  input  logic                 i_valid,
  output logic                 ready,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [2*WIDTH-1:0]   P
);

  if (!params_ok(WIDTH, K, EARLY_TERM)) begin : g_bad_params
    $error("seq_mul_radix: illegal parameters WIDTH=%0d K=%0d EARLY_TERM=%0d",
           WIDTH, K, EARLY_TERM);
  end

  state_e             state_q, state_d;
  logic               ready_q, o_valid_q;
  logic [2*WIDTH-1:0] p_q;
  logic               load, step, finish, last;
  logic [2*WIDTH-1:0] result;

  seq_mul_dp #(
    .WIDTH      (WIDTH),
    .K          (K),
    .EARLY_TERM (EARLY_TERM)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .step_i      (step),
    .finish_i    (finish),
    .a_i         (A),
    .b_i         (B),
    .is_signed_i (is_signed),
    .last_o      (last),
    .result_o    (result)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready/o_valid are registered copies of the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      o_valid_q <= 1'b0;
      p_q       <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      o_valid_q <= (state_d == DONE);
      if (finish) p_q <= result;
    end
  end

  assign ready   = ready_q;
  assign o_valid = o_valid_q;
  assign P       = p_q;

endmodule

// File: tb/tb_seq_mul_radix.sv
// Scoreboard bench for seq_mul_radix across several WIDTH/K/EARLY_TERM configurations,
// each with its own reset, driver, random backpressure and output monitor.
module tb_seq_mul_radix;

  localparam int NCFG  = 7;
  localparam int NRAND = 1000;

  typedef struct {
    logic [31:0] p;
    int          lat;
    int          t_acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int cfg_w(input int i);
    case (i)
      4, 5, 6: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_k(input int i);
    case (i)
      2, 4:    return 1;
      3, 5:    return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_e(input int i);
    case (i)
      1, 6:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mask32(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Integer value of a w-bit operand under the chosen signedness.
  function automatic longint sval(input logic [31:0] v, input bit s, input int w);
    longint u;
    u = longint'(v & mask32(w));
    if (s && (u >= (longint'(1) << (w - 1)))) return u - (longint'(1) << w);
    return u;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input bit s, input int w);
    longint pr;
    pr = sval(a, s, w) * sval(b, s, w);
    return 32'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Cycles from accept to o_valid: full digit count, or digits needed to cover |B|.
  function automatic int ref_lat(input logic [31:0] b, input bit s, input int w,
                                 input int k, input int e);
    longint mag;
    int     nb;
    int     d;
    if (e == 0) return w / k;
    mag = sval(b, s, w);
    if (mag < 0) mag = -mag;
    nb = 0;
    while ((mag >> nb) != 0) nb++;
    d = (nb + k - 1) / k;
    return (d < 1) ? 1 : d;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = cfg_w(g);
    localparam int KK = cfg_k(g);
    localparam int E  = cfg_e(g);

    logic             rst_n, is_signed, i_valid, ready, o_valid, o_ready;
    logic [W-1:0]     a, b;
    logic [2*W-1:0]   p;
    bit               rand_ordy = 1'b0;
    exp_t             sb[$];

    seq_mul_radix #(
      .WIDTH      (W),
      .K          (KK),
      .EARLY_TERM (E)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (a),
      .B         (b),
      .is_signed (is_signed),
      .i_valid   (i_valid),
      .ready     (ready),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .P         (p)
    );

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input bit s);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (ready !== 1'b1 && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      if (ready !== 1'b1) begin
        check($sformatf("cfg%0d accept_timeout", g), 32'(ready), 32'd1);
        return;
      end
      a         = W'(av);
      b         = W'(bv);
      is_signed = s;
      i_valid   = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      e.p     = ref_prod(av, bv, s, W);
      e.lat   = ref_lat(bv, s, W, KK, E);
      e.t_acc = cyc;
      sb.push_back(e);
    endtask

    task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || o_valid === 1'b1) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("cfg%0d drain_pending", g), 32'(sb.size()), 32'd0);
    endtask

    initial begin
      forever begin
        @(negedge clk);
        if (rand_ordy) o_ready = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
        @(negedge clk);
        if (o_valid === 1'b1 && !prev) begin
          if (sb.size() == 0) begin
            check($sformatf("cfg%0d spurious_o_valid", g), 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("cfg%0d P", g), 32'(p), e.p);
            check($sformatf("cfg%0d latency", g), 32'(cyc - e.t_acc), 32'(e.lat));
          end
        end
        prev = (o_valid === 1'b1);
      end
    end

    initial begin
      logic [2*W-1:0] hold;
      logic [31:0]    top_bit;
      int             n;
      logic [31:0]    bv;

      rst_n     = 1'b0;
      i_valid   = 1'b0;
      o_ready   = 1'b0;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      check($sformatf("cfg%0d reset_ready", g),   32'(ready),   32'd1);
      check($sformatf("cfg%0d reset_o_valid", g), 32'(o_valid), 32'd0);
      check($sformatf("cfg%0d reset_P", g),       32'(p),       32'd0);
      rst_n     = 1'b1;
      rand_ordy = 1'b1;

      send(32'd13, 32'd11, 1'b0);
      send(32'hFFFF_FF80, 32'hFFFF_FF80, 1'b1);
      send(32'hFFFF_FFFD, 32'd5, 1'b1);
      send(32'hFF, 32'hFF, 1'b0);
      send(32'h55, 32'h01, 1'b0);
      send(32'h55, 32'h00, 1'b0);
      send(32'h55, 32'h80, 1'b0);
      wait_drain();

      // Backpressure: result must hold while o_ready stays low, and i_valid is ignored.
      rand_ordy = 1'b0;
      o_ready   = 1'b0;
      send(32'hA5C3, 32'h3C5A, 1'b1);
      n = 0;
      while (o_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("cfg%0d bp_o_valid_up", g), 32'(o_valid), 32'd1);
      hold = p;
      repeat (10) begin
        i_valid = 1'b1;
        a       = W'($urandom);
        b       = W'($urandom);
        @(negedge clk);
        check($sformatf("cfg%0d bp_o_valid", g), 32'(o_valid), 32'd1);
        check($sformatf("cfg%0d bp_ready", g),   32'(ready),   32'd0);
        check($sformatf("cfg%0d bp_P", g),       32'(p),       32'(hold));
      end
      o_ready = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      o_ready = 1'b0;
      check($sformatf("cfg%0d hs_o_valid", g), 32'(o_valid), 32'd0);
      check($sformatf("cfg%0d hs_ready", g),   32'(ready),   32'd1);
      check($sformatf("cfg%0d hs_P_kept", g),  32'(p),       32'(hold));

      // Asynchronous reset in the middle of a computation.
      rand_ordy = 1'b1;
      top_bit   = 32'd1 << (W - 1);
      send(top_bit | 32'd3, top_bit | 32'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check($sformatf("cfg%0d async_rst_ready", g),   32'(ready),   32'd1);
      check($sformatf("cfg%0d async_rst_o_valid", g), 32'(o_valid), 32'd0);
      check($sformatf("cfg%0d async_rst_P", g),       32'(p),       32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(32'd7, 32'd9, 1'b0);
      wait_drain();

      repeat (NRAND) begin
        bv = $urandom;
        if ($urandom_range(0, 1) == 1) bv = bv & mask32($urandom_range(0, W));
        send($urandom, bv, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();
      n_done++;
    end
  end

  initial begin
    wait (n_done == NCFG);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: run incomplete, %0d of %0d configurations done", n_done, NCFG);
    $fatal(1, "watchdog expired");
  end

endmodule
